// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: states, opcodes,
// ALU operations and datapath mux selects.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  typedef enum logic [1:0] {CLASS_OTHER, CLASS_R, CLASS_I} op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       alu_out_en;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation select for R- and I-type arithmetic, plus legality of the
// funct fields for those classes.
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  op_class_t  op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (op_class)
      CLASS_R: begin
        case (funct3)
          F3_ADD:  alu_op = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  if (funct7b5) illegal = 1'b1; else alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      CLASS_I: begin
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 main controller: sequences each instruction and drives the
// ALU, operand muxes, memory/register enables and PC/IR strobes.
module mc_control_fsm
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_out_en,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       halted
);

  state_t     state;
  ctrl_t      ctrl;
  op_class_t  op_class;
  logic [2:0] dec_op;
  logic       dec_illegal;

  assign op_class = (opcode == OP_RTYPE) ? CLASS_R :
                    (opcode == OP_ITYPE) ? CLASS_I : CLASS_OTHER;

  alu_decoder u_alu_decoder (
    .op_class (op_class),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_op   (dec_op),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= (funct3 == F3_WORD) ? S_MEMADR : S_HALT;
            OP_RTYPE:  state <= dec_illegal ? S_HALT : S_EXEC_R;
            OP_ITYPE:  state <= dec_illegal ? S_HALT : S_EXEC_I;
            OP_BRANCH: state <= (funct3 == F3_BEQ) ? S_BEQ : S_HALT;
            OP_JAL:    state <= S_JAL;
            default:   state <= S_HALT;
          endcase
        end
        S_MEMADR: state <= (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_JAL: state <= S_ALUWB;
        S_ALUWB, S_BEQ: state <= S_FETCH;
        default:  state <= S_HALT;
      endcase
    end
  end

  // Moore decode; only the mem_ready- and zero-qualified strobes look at inputs.
  // Holding rst forces everything quiet so an abandoned instruction writes nothing.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_req    = 1'b1;
          ctrl.alu_src_a  = SRC_A_PC;
          ctrl.alu_src_b  = SRC_B_FOUR;
          ctrl.result_src = RES_ALU;
          ctrl.ir_write   = mem_ready;
          ctrl.pc_write   = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a  = SRC_A_OLD_PC;
          ctrl.alu_src_b  = SRC_B_IMM;
          ctrl.alu_out_en = 1'b1;
        end
        S_MEMADR: begin
          ctrl.alu_src_a  = SRC_A_RS1;
          ctrl.alu_src_b  = SRC_B_IMM;
          ctrl.alu_out_en = 1'b1;
        end
        S_MEMRD: begin
          ctrl.mem_req    = 1'b1;
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALU_OUT;
        end
        S_MEMWB: begin
          ctrl.result_src = RES_MEM;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_req    = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.adr_src    = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_EXEC_R, S_EXEC_I: begin
          ctrl.alu_src_a  = SRC_A_RS1;
          ctrl.alu_src_b  = (state == S_EXEC_R) ? SRC_B_RS2 : SRC_B_IMM;
          ctrl.alu_op     = dec_op;
          ctrl.alu_out_en = 1'b1;
        end
        S_ALUWB: begin
          ctrl.result_src = RES_ALU_OUT;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BEQ: begin
          ctrl.alu_src_a  = SRC_A_RS1;
          ctrl.alu_src_b  = SRC_B_RS2;
          ctrl.alu_op     = ALU_SUB;
          ctrl.result_src = RES_ALU_OUT;
          ctrl.instr_done = 1'b1;
          ctrl.pc_write   = zero;
        end
        S_JAL: begin
          ctrl.alu_src_a  = SRC_A_OLD_PC;
          ctrl.alu_src_b  = SRC_B_FOUR;
          ctrl.result_src = RES_ALU_OUT;
          ctrl.pc_write   = 1'b1;
          ctrl.alu_out_en = 1'b1;
        end
        S_HALT:  ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign reg_write  = ctrl.reg_write;
  assign alu_out_en = ctrl.alu_out_en;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign instr_done = ctrl.instr_done;
  assign halted     = ctrl.halted;
  assign imm_src    = rst ? IMM_I : imm_src_of(opcode);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded into its list of
// expected control steps from the ISA rules, then replayed against the DUT.
module tb_mc_control_fsm;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_out_en;
    logic [1:0] a, b;
    logic [2:0] op;
    logic [1:0] res;
    logic       done, halted;
  } vec_t;

  typedef struct {
    string tag;
    vec_t  v;
    vec_t  cmask;   // strobes that fire only on the mem_ready cycle
    bit    wt;
    bit    is_beq;
    bit    is_rst;
  } step_t;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7;
    int         delay;
    logic       zero;
    int         rst_at;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst, funct7b5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_out_en;
  logic       instr_done, halted;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_op;
  vec_t       got;

  int n_cmp = 0;
  int n_bad = 0;
  step_t q[$];

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_out_en(alu_out_en), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
    .instr_done(instr_done), .halted(halted)
  );

  assign got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_out_en,
                alu_src_a, alu_src_b, alu_op, result_src, instr_done, halted};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, actual[17:0], expected[17:0]);
    end
  endtask

  // ISA-level view: is the instruction legal, and what arithmetic does it do.
  function automatic bit legal_ref(input instr_t i, output logic [2:0] op);
    op = 3'd0;
    case (i.opcode)
      LW, SW: return i.f3 == 3'b010;
      BR:     return i.f3 == 3'b000;
      JL:     return 1'b1;
      RT: begin
        if (i.f3 == 3'b000) begin op = i.f7 ? 3'd1 : 3'd0; return 1'b1; end
        if (i.f3 == 3'b111 && !i.f7) begin op = 3'd2; return 1'b1; end
        return 1'b0;
      end
      IT: begin
        if (i.f3 == 3'b000) return 1'b1;
        if (i.f3 == 3'b111) begin op = 3'd2; return 1'b1; end
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] opc);
    if (opc == SW) return 2'd1;
    if (opc == BR) return 2'd2;
    if (opc == JL) return 2'd3;
    return 2'd0;
  endfunction

  function automatic void push(input string tag, input vec_t v, input vec_t cm,
                               input bit wt, input bit is_beq, input bit is_rst);
    step_t s;
    s.tag = tag; s.v = v; s.cmask = cm; s.wt = wt; s.is_beq = is_beq; s.is_rst = is_rst;
    q.push_back(s);
  endfunction

  function automatic void build(input instr_t i);
    vec_t v, cm;
    logic [2:0] op;
    bit ok = legal_ref(i, op);
    v = '0; cm = '0;
    v.mem_req = 1; v.a = 2'd0; v.b = 2'd2; v.res = 2'd2; v.ir_write = 1; v.pc_write = 1;
    cm.ir_write = 1; cm.pc_write = 1;
    push("fetch", v, cm, 1, 0, 0);
    v = '0; v.a = 2'd1; v.b = 2'd1; v.alu_out_en = 1;
    push("decode", v, '0, 0, 0, 0);
    if (!ok) begin
      v = '0; v.halted = 1;
      for (int k = 0; k < 3; k++) push("halt", v, '0, 0, 0, 0);
      push("halt_rst", '0, '0, 0, 0, 1);
      return;
    end
    case (i.opcode)
      LW, SW: begin
        v = '0; v.a = 2'd2; v.b = 2'd1; v.alu_out_en = 1;
        push("memadr", v, '0, 0, 0, 0);
        if (i.opcode == LW) begin
          v = '0; v.mem_req = 1; v.adr_src = 1; v.res = 2'd0;
          push("memrd", v, '0, 1, 0, 0);
          v = '0; v.res = 2'd1; v.reg_write = 1; v.done = 1;
          push("memwb", v, '0, 0, 0, 0);
        end else begin
          v = '0; v.mem_req = 1; v.mem_write = 1; v.adr_src = 1; v.done = 1;
          cm = '0; cm.done = 1;
          push("memwr", v, cm, 1, 0, 0);
        end
      end
      BR: begin
        v = '0; v.a = 2'd2; v.b = 2'd0; v.op = 3'd1; v.done = 1;
        push("beq", v, '0, 0, 1, 0);
      end
      default: begin
        v = '0; v.alu_out_en = 1;
        if (i.opcode == JL) begin
          v.a = 2'd1; v.b = 2'd2; v.pc_write = 1;
          push("jal", v, '0, 0, 0, 0);
        end else begin
          v.a = 2'd2; v.b = (i.opcode == RT) ? 2'd0 : 2'd1; v.op = op;
          push("exec", v, '0, 0, 0, 0);
        end
        v = '0; v.res = 2'd0; v.reg_write = 1; v.done = 1;
        push("aluwb", v, '0, 0, 0, 0);
      end
    endcase
  endfunction

  task automatic run_instr(input instr_t i);
    int    cyc = 0;
    int    wcnt = i.delay;
    step_t s;
    vec_t  e;
    logic  r;
    build(i);
    while (q.size() > 0) begin
      s = q[0];
      @(negedge clk);
      r         = s.is_rst || (cyc == i.rst_at);
      rst       = r;
      opcode    = i.opcode;
      funct3    = i.f3;
      funct7b5  = i.f7;
      zero      = s.is_beq ? i.zero : 1'($urandom);
      mem_ready = s.wt ? (wcnt == 0) : 1'($urandom);
      #2;
      if (r) e = '0;
      else begin
        e = s.v;
        if (s.wt && !mem_ready) e = e & ~s.cmask;
        if (s.is_beq) e.pc_write = zero;
      end
      check($sformatf("%s op=%b f3=%b c%0d", r ? "reset" : s.tag, i.opcode, i.f3, cyc),
            32'(got), 32'(e));
      check($sformatf("imm_src op=%b c%0d", i.opcode, cyc),
            32'(imm_src), 32'(r ? 2'd0 : imm_ref(i.opcode)));
      if (r) q.delete();
      else if (s.wt && !mem_ready) wcnt--;
      else begin
        void'(q.pop_front());
        wcnt = i.delay;
      end
      cyc++;
    end
  endtask

  function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input int delay, input logic z, input int rst_at);
    instr_t i;
    i.opcode = opc; i.f3 = f3; i.f7 = f7; i.delay = delay; i.zero = z; i.rst_at = rst_at;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    int         k = int'($urandom_range(0, 13));
    logic [6:0] opc;
    logic [2:0] f3 = 3'($urandom);
    case (k)
      0, 1:    opc = LW;
      2, 3:    opc = SW;
      4, 5, 6: opc = RT;
      7, 8:    opc = IT;
      9, 10:   opc = BR;
      11:      opc = JL;
      12:      opc = 7'($urandom);
      default: opc = LUI;
    endcase
    if ((opc == LW || opc == SW) && $urandom_range(0, 9) != 0) f3 = 3'b010;
    if (opc == BR && $urandom_range(0, 9) != 0) f3 = 3'b000;
    if ((opc == RT || opc == IT) && $urandom_range(0, 4) != 0)
      f3 = $urandom_range(0, 1) ? 3'b111 : 3'b000;
    return mk(opc, f3, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
              ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 9)) : -1);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #2;
      check("reset_vec", 32'(got), 32'(0));
      check("reset_imm", 32'(imm_src), 32'(0));
    end
    run_instr(mk(RT, 3'b000, 1'b0, 0, 1'b0, -1));   // add
    run_instr(mk(RT, 3'b000, 1'b1, 0, 1'b0, -1));   // sub
    run_instr(mk(RT, 3'b111, 1'b0, 0, 1'b0, -1));   // and
    run_instr(mk(LW, 3'b010, 1'b0, 3, 1'b0, -1));   // lw with wait states
    run_instr(mk(BR, 3'b000, 1'b0, 0, 1'b1, -1));   // beq taken
    run_instr(mk(BR, 3'b000, 1'b0, 0, 1'b0, -1));   // beq not taken
    run_instr(mk(LUI, 3'b000, 1'b0, 0, 1'b0, -1));  // unsupported opcode
    run_instr(mk(RT, 3'b001, 1'b0, 0, 1'b0, -1));   // illegal funct3
    run_instr(mk(SW, 3'b010, 1'b0, 3, 1'b0, 7));    // reset while store waits
    run_instr(mk(IT, 3'b111, 1'b1, 1, 1'b0, -1));   // andi
    run_instr(mk(JL, 3'b000, 1'b0, 2, 1'b0, -1));   // jal
    for (int n = 0; n < 300; n++) run_instr(rand_instr());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the RV32 core.
- Sits directly upstream of the ALU: it sequences every instruction and drives alu_op, the ALU operand muxes, the register and memory enables, and the PC and IR write strobes.
- It consumes the ALU zero flag to resolve beq.
- Supported instructions: add, sub, and, addi, andi, lw, sw, beq, jal. Any other encoding halts the core.

Parameters:
- None. All encodings live in the shared package.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store (valid with mem_req)
- adr_src  out  1  0=PC, 1=ALUOut
- ir_write  out  1  load IR and old_pc
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register file write enable
- alu_out_en  out  1  load ALUOut register
- alu_src_a  out  2  00=PC, 01=old_pc, 10=rs1 reg
- alu_src_b  out  2  00=rs2 reg, 01=imm, 10=const 4
- alu_op  out  3  000 ADD, 001 SUB, 010 AND
- result_src  out  2  00=ALUOut, 01=mem rdata, 10=ALU direct
- imm_src  out  2  00=I, 01=S, 10=B, 11=J (combinational from opcode)
- instr_done  out  1  one-cycle pulse on instruction retire
- halted  out  1  sticky illegal-instruction flag

Behaviour:
- Reset:
  - The state is FETCH in the cycle after rst is sampled high.
  - While rst=1, every strobe (mem_req, ir_write, pc_write, reg_write, alu_out_en, instr_done) is 0 and halted=0.
  - Mux selects and alu_op are 00/000 during reset.
  - Reset mid-instruction abandons the instruction; no partial writes occur in the reset cycle.
- Outputs are Moore-decoded from state, except the strobes qualified by mem_ready or zero, which are noted below.
- FETCH:
  - mem_req=1, adr_src=0, a=PC, b=4, ADD, result_src=10.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1; the FSM then goes to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - a=old_pc, b=imm, ADD, alu_out_en=1 (branch/jump target).
  - Transitions by opcode:
    - 0000011 or 0100011: MEMADR
    - 0110011: EXEC_R
    - 0010011: EXEC_I
    - 1100011: BEQ
    - 1101111: JAL
  - Illegal opcode or funct combination goes to HALT.
    - lw and sw require funct3=010; beq requires funct3=000.
    - R-type accepts funct3 000 or 111 only; funct7b5=1 is legal only with funct3=000.
    - I-type accepts funct3 000 or 111.
- MEMADR: a=rs1, b=imm, ADD, alu_out_en=1. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, adr_src=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1. On mem_ready it pulses instr_done and goes to FETCH.
- EXEC_R:
  - a=rs1, b=rs2, alu_out_en=1. Goes to ALUWB.
  - alu_op: ADD (funct7b5=0, funct3=000), SUB (funct7b5=1, funct3=000), AND (funct3=111).
- EXEC_I: a=rs1, b=imm, alu_out_en=1, alu_op ADD (funct3=000) or AND (funct3=111). Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ:
  - a=rs1, b=rs2, SUB, result_src=00, instr_done=1. Goes to FETCH.
  - pc_write=zero (combinational, same cycle). ALUOut still holds the target and is not loaded.
- JAL: a=old_pc, b=4, ADD, result_src=00, pc_write=1, alu_out_en=1. Goes to ALUWB (writes the link).
- HALT: terminal state. halted=1, all strobes 0. Only rst exits.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- mem_req stays high continuously until mem_ready.
- alu_op defaults to ADD in states not listed above.

Decomposition:
- Package riscv_mc_pkg:
  - state enum
  - opcode constants
  - ALU op constants: ADD=000, SUB=001, AND=010
  - alu_src_a, alu_src_b, result_src and imm_src encodings
- Sub-module alu_decoder:
  - Inputs: class (R/I/other), funct3, funct7b5.
  - Outputs: alu_op and illegal (combinational).

Test Plan:
- Reset then add x3,x1,x2 with mem_ready=1 every cycle -> states FETCH, DECODE, EXEC_R, ALUWB; alu_op=000 in EXEC_R; reg_write=1 and instr_done=1 in ALUWB; 4 cycles total.
- sub then and (funct7b5=1/funct3=000, funct3=111) -> alu_op=001 then 010 in EXEC_R.
- lw with mem_ready held low 3 cycles in both FETCH and MEMRD -> mem_req stays 1 throughout; ir_write/pc_write fire only on the ready cycle; MEMWB reg_write=1; 5 cycles + 6 wait cycles.
- beq with zero=1, then with zero=0 -> pc_write=1 in BEQ for the first, 0 for the second; instr_done=1 both times; 3 cycles each.
- Opcode 0110111 (lui), and R-type funct3=001 -> HALT, halted=1, no further mem_req; rst=1 returns to FETCH with halted=0.
- Reset asserted in MEMWR while waiting -> next cycle FETCH; mem_write=0 and no instr_done pulse.
